// File: rtl/evrisim_sram_fifo_ctrl_if.sv
// evrisim_sram_fifo_ctrl_if: stream and SRAM-port bundle for the SRAM-backed FIFO controller
//   flush_i                          synchronous clear request
//   in_valid_i/in_ready_o/in_data_i  input stream
//   out_valid_o/out_ready_i/out_data_o output stream, level_o words held
//   sram_csb0_o/addr0_o/din0_o       SRAM write port (active-low select)
//   sram_csb1_o/addr1_o/dout1_i      SRAM read port (active-low select, 1-cycle latency)
interface evrisim_sram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 9
);
    logic                  flush_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic [ADDR_WIDTH:0]   level_o;
    logic                  sram_csb0_o;
    logic [ADDR_WIDTH-1:0] sram_addr0_o;
    logic [DATA_WIDTH-1:0] sram_din0_o;
    logic                  sram_csb1_o;
    logic [ADDR_WIDTH-1:0] sram_addr1_o;
    logic [DATA_WIDTH-1:0] sram_dout1_i;

    modport slave (
        input  flush_i, in_valid_i, in_data_i, out_ready_i, sram_dout1_i,
        output in_ready_o, out_valid_o, out_data_o, level_o,
               sram_csb0_o, sram_addr0_o, sram_din0_o, sram_csb1_o, sram_addr1_o
    );

    modport master (
        output flush_i, in_valid_i, in_data_i, out_ready_i, sram_dout1_i,
        input  in_ready_o, out_valid_o, out_data_o, level_o,
               sram_csb0_o, sram_addr0_o, sram_din0_o, sram_csb1_o, sram_addr1_o
    );
endinterface

// File: rtl/evrisim_sram_fifo_ctrl.sv
// evrisim_sram_fifo_ctrl: streaming FIFO built on a 1W/1R SRAM with a 3-entry output buffer
//   clk_i  single clock (SRAM clocks tied to it)
//   rst_i  synchronous active-high reset
//   bus    evrisim_sram_fifo_ctrl_if.slave: input/output streams, level, SRAM ports
module evrisim_sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 320
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    evrisim_sram_fifo_ctrl_if.slave  bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         mem_count;
    logic                  rd_pend;
    logic [1:0]            obuf_cnt, cap_idx;
    logic [DATA_WIDTH-1:0] obuf [3];
    logic                  clr, wr_acc, rd_iss, pop;

    assign clr          = rst_i || bus.flush_i;
    assign bus.in_ready_o = !rst_i && mem_count < CW'(DEPTH);
    assign wr_acc       = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;
    // Reads are admitted only while the buffer can absorb every word already in flight,
    // so a capture never finds the buffer full and out_ready_i never reaches the SRAM.
    assign rd_iss       = !clr && mem_count != '0 && ({1'b0, obuf_cnt} + 3'(rd_pend)) < 3'd3;
    assign pop          = bus.out_valid_o && bus.out_ready_i && !bus.flush_i;
    // Slot the captured word lands in after this cycle's pop has shifted the buffer.
    assign cap_idx      = obuf_cnt - 2'(pop);

    assign bus.sram_csb0_o  = !wr_acc;
    assign bus.sram_addr0_o = wr_ptr;
    assign bus.sram_din0_o  = bus.in_data_i;
    assign bus.sram_csb1_o  = !rd_iss;
    assign bus.sram_addr1_o = rd_ptr;

    assign bus.out_valid_o = obuf_cnt != '0;
    assign bus.out_data_o  = obuf[0];
    assign bus.level_o     = mem_count + CW'(rd_pend) + CW'(obuf_cnt);

    always_ff @(posedge clk_i) begin
        if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            rd_pend   <= 1'b0;
            obuf_cnt  <= '0;
            obuf[0]   <= '0;
            obuf[1]   <= '0;
            obuf[2]   <= '0;
        end else begin
            if (wr_acc) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (rd_iss) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            mem_count <= mem_count + CW'(wr_acc) - CW'(rd_iss);
            rd_pend   <= rd_iss;
            obuf_cnt  <= cap_idx + 2'(rd_pend);
            // sram_dout1_i is only selected in the cycle after an issue, when it is defined.
            obuf[0]   <= (rd_pend && cap_idx == 2'd0) ? bus.sram_dout1_i : pop ? obuf[1] : obuf[0];
            obuf[1]   <= (rd_pend && cap_idx == 2'd1) ? bus.sram_dout1_i : pop ? obuf[2] : obuf[1];
            obuf[2]   <= (rd_pend && cap_idx == 2'd2) ? bus.sram_dout1_i : obuf[2];
        end
    end
endmodule

// File: tb/tb_evrisim_sram_fifo_ctrl.sv
// tb_evrisim_sram_fifo_ctrl: directed and random stimulus with SRAM model and FIFO scoreboard
module tb_evrisim_sram_fifo_ctrl;
    localparam int DW = 11;
    localparam int AW = 9;
    localparam int DEPTH = 320;
    localparam logic [DW-1:0] POISON = 11'h4B2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    evrisim_sram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
    evrisim_sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
    );

    logic [DW-1:0] mem [512];
    logic [DW-1:0] sram_dout = POISON;
    assign bus.sram_dout1_i = sram_dout;

    // Read data is only meaningful the cycle after a read; otherwise a poison word is driven.
    always @(posedge clk_i) begin
        if (!bus.sram_csb0_o) mem[bus.sram_addr0_o] <= bus.sram_din0_o;
        sram_dout <= !bus.sram_csb1_o ? mem[bus.sram_addr1_o] : POISON;
    end

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int collisions = 0;
    int wraps = 0;
    int exp_wa = 0;
    int exp_ra = 0;
    logic [DW-1:0] q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        chk("level", 32'(bus.level_o), 32'(q.size()));
        if (rst_i || bus.flush_i) begin
            chk("csb_clr", {bus.sram_csb0_o, bus.sram_csb1_o}, 32'd3);
            q.delete();
            exp_wa = 0;
            exp_ra = 0;
        end else begin
            if (bus.out_valid_o && bus.out_ready_i) begin
                pops++;
                if (q.size() == 0) chk("underflow", 32'd1, 32'd0);
                else chk("data", bus.out_data_o, q.pop_front());
            end
            if (bus.in_valid_i && bus.in_ready_o) q.push_back(bus.in_data_i);
            if (!bus.sram_csb0_o && !bus.sram_csb1_o && bus.sram_addr0_o == bus.sram_addr1_o) collisions++;
            if (!bus.sram_csb0_o) begin
                chk("wr_addr", bus.sram_addr0_o, exp_wa);
                exp_wa = (exp_wa == DEPTH - 1) ? 0 : exp_wa + 1;
            end
            if (!bus.sram_csb1_o) begin
                chk("rd_addr", bus.sram_addr1_o, exp_ra);
                if (exp_ra == DEPTH - 1) wraps++;
                exp_ra = (exp_ra == DEPTH - 1) ? 0 : exp_ra + 1;
            end
        end
    end

    int acc;
    int cyc;
    int p0;
    int w0;

    initial begin
        bus.flush_i = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_data_i = '0;
        bus.out_ready_i = 1'b0;
        repeat (3) step();
        chk("rst_valid", bus.out_valid_o, 0);
        chk("rst_data", bus.out_data_o, 0);
        chk("rst_level", bus.level_o, 0);
        chk("rst_csb", {bus.sram_csb0_o, bus.sram_csb1_o}, 3);
        chk("rst_ready", bus.in_ready_o, 0);
        rst_i = 1'b0;
        #1;
        chk("ready_after_rst", bus.in_ready_o, 1);

        bus.out_ready_i = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_data_i = 11'h001;
        step();
        chk("t1_v1", bus.out_valid_o, 0);
        bus.in_data_i = 11'h002;
        step();
        chk("t1_v2", bus.out_valid_o, 0);
        bus.in_data_i = 11'h7FF;
        step();
        bus.in_valid_i = 1'b0;
        chk("t1_v3", bus.out_valid_o, 1);
        chk("t1_d1", bus.out_data_o, 11'h001);
        step();
        chk("t1_d2", bus.out_data_o, 11'h002);
        step();
        chk("t1_d3", bus.out_data_o, 11'h7FF);
        step();
        chk("t1_empty", bus.out_valid_o, 0);

        bus.out_ready_i = 1'b0;
        bus.in_valid_i = 1'b1;
        acc = 0;
        for (int k = 0; k < 400; k++) begin
            bus.in_data_i = DW'(k);
            if (bus.in_ready_o) acc++;
            step();
        end
        bus.in_valid_i = 1'b0;
        chk("t2_accepted", acc, 323);
        chk("t2_ready", bus.in_ready_o, 0);
        chk("t2_level", bus.level_o, 323);
        p0 = pops;
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < 400 && bus.level_o != 0; k++) step();
        chk("t2_drained", pops - p0, 323);
        chk("t2_level0", bus.level_o, 0);

        p0 = pops;
        w0 = wraps;
        acc = 0;
        cyc = 0;
        bus.in_valid_i = 1'b1;
        while (acc < 1000 && cyc < 2000) begin
            bus.in_data_i = DW'(acc * 7 + 3);
            if (bus.in_ready_o) acc++;
            step();
            cyc++;
        end
        bus.in_valid_i = 1'b0;
        chk("t3_cycles", cyc, 1000);
        repeat (4) step();
        chk("t3_out", pops - p0, 1000);
        chk("t3_rd_wraps", wraps - w0, 3);

        p0 = pops;
        acc = 0;
        cyc = 0;
        while (acc < 5000 && cyc < 40000) begin
            bus.in_valid_i = 1'($urandom_range(0, 1));
            bus.out_ready_i = 1'($urandom_range(0, 1));
            bus.in_data_i = DW'($urandom);
            if (bus.in_valid_i && bus.in_ready_o) acc++;
            step();
            cyc++;
        end
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < 400 && bus.level_o != 0; k++) step();
        chk("t4_in", acc, 5000);
        chk("t4_out", pops - p0, 5000);
        chk("t4_level0", bus.level_o, 0);

        bus.out_ready_i = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i = 11'h0AA;
        step();
        bus.in_valid_i = 1'b0;
        chk("t5_issue", bus.sram_csb1_o, 0);
        step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("t5_valid", bus.out_valid_o, 0);
        chk("t5_level", bus.level_o, 0);
        bus.out_ready_i = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_data_i = 11'h155;
        step();
        bus.in_valid_i = 1'b0;
        step();
        step();
        chk("t5_first_valid", bus.out_valid_o, 1);
        chk("t5_first_data", bus.out_data_o, 11'h155);
        step();

        bus.out_ready_i = 1'b0;
        bus.in_valid_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.in_data_i = DW'(11'h200 + k);
            step();
        end
        bus.in_valid_i = 1'b0;
        repeat (3) step();
        chk("t6_level", bus.level_o, 6);
        chk("t6_head", bus.out_data_o, 11'h200);
        rst_i = 1'b1;
        bus.in_valid_i = 1'b1;
        step();
        chk("t6_valid", bus.out_valid_o, 0);
        chk("t6_data", bus.out_data_o, 0);
        chk("t6_lvl", bus.level_o, 0);
        chk("t6_csb", {bus.sram_csb0_o, bus.sram_csb1_o}, 3);
        chk("t6_ready", bus.in_ready_o, 0);
        rst_i = 1'b0;
        bus.in_valid_i = 1'b0;
        step();
        chk("t6_ready_after", bus.in_ready_o, 1);
        bus.out_ready_i = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_data_i = 11'h321;
        step();
        bus.in_valid_i = 1'b0;
        step();
        step();
        chk("t6_post_valid", bus.out_valid_o, 1);
        chk("t6_post_data", bus.out_data_o, 11'h321);
        step();
        chk("t6_post_level", bus.level_o, 0);

        chk("collisions", collisions, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
